// File: rtl/dual_slot_rr_arbiter_10_if.sv
// Request/release and grant bundle for the dual-slot
// round-robin arbiter.
interface dual_slot_rr_arbiter_10_if;
    logic [9:0] req;
    logic [9:0] rel;
    logic [9:0] gnt;
    logic [9:0] gnt_new;
    logic [9:0] revoked;
    logic [1:0] active_cnt;
    logic       one_or_two;

    modport master (
        output req, rel,
        input  gnt, gnt_new, revoked,
        input  active_cnt, one_or_two
    );

    modport slave (
        input  req, rel,
        output gnt, gnt_new, revoked,
        output active_cnt, one_or_two
    );
endinterface

// File: rtl/dual_slot_rr_arbiter_10.sv
// Two-slot resource shared by 10 requesters, round-robin,
// with per-slot hold limit and release.
module dual_slot_rr_arbiter_10 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input logic clk,
    input logic rst,
    dual_slot_rr_arbiter_10_if.slave bus
);
    localparam int N = 10;
    localparam bit TO_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        TO_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

    typedef enum logic {
        FREE  = 1'b0,
        OWNED = 1'b1
    } slot_st_t;

    slot_st_t          st_q   [2];
    slot_st_t          st_d   [2];
    logic [3:0]        own_q  [2];
    logic [3:0]        own_d  [2];
    logic [HOLD_W-1:0] hold_q [2];
    logic [HOLD_W-1:0] hold_d [2];

    logic [3:0]   ptr_q, ptr_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [N-1:0] new_q, new_d;
    logic [N-1:0] rev_q, rev_d;

    logic [N-1:0] elig;
    logic [1:0]   rel_hit;
    logic [1:0]   tmo;
    logic [1:0]   freed;
    logic [1:0]   avail;
    logic         win_vld;
    logic [3:0]   win_idx;
    logic [4:0]   pos;
    logic         take;
    logic         tgt;
    logic [1:0]   cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                st_q[s]   <= FREE;
                own_q[s]  <= '0;
                hold_q[s] <= '0;
            end
            ptr_q <= '0;
            gnt_q <= '0;
            new_q <= '0;
            rev_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                st_q[s]   <= st_d[s];
                own_q[s]  <= own_d[s];
                hold_q[s] <= hold_d[s];
            end
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
            new_q <= new_d;
            rev_q <= rev_d;
        end
    end

    // Rotating search: first eligible requester from ptr
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        pos     = '0;
        elig    = bus.req & ~gnt_q;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr_q} + 5'(k);
            if (pos > 5'd9)
                pos = pos - 5'd10;
            if (!win_vld && elig[pos[3:0]]) begin
                win_vld = 1'b1;
                win_idx = pos[3:0];
            end
        end
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            st_d[s]   = st_q[s];
            own_d[s]  = own_q[s];
            hold_d[s] = hold_q[s];
        end
        ptr_d   = ptr_q;
        new_d   = '0;
        rev_d   = '0;
        gnt_d   = '0;
        rel_hit = '0;
        tmo     = '0;
        freed   = '0;
        avail   = '0;

        for (int s = 0; s < 2; s++) begin
            if (st_q[s] == OWNED) begin
                rel_hit[s] = bus.rel[own_q[s]];
                tmo[s] = TO_EN && !rel_hit[s] &&
                         (hold_q[s] == HOLD_LAST);
            end
            freed[s] = rel_hit[s] | tmo[s];
            avail[s] = (st_q[s] == FREE) | freed[s];
            if (tmo[s])
                rev_d[own_q[s]] = 1'b1;
            if (freed[s])
                st_d[s] = FREE;
            else if (st_q[s] == OWNED)
                hold_d[s] = hold_q[s] + 1'b1;
        end

        take = win_vld && (|avail);
        tgt  = !avail[0];
        if (take) begin
            st_d[tgt]     = OWNED;
            own_d[tgt]    = win_idx;
            hold_d[tgt]   = '0;
            new_d[win_idx] = 1'b1;
            ptr_d = (win_idx == 4'd9) ? 4'd0
                                      : win_idx + 4'd1;
        end

        for (int s = 0; s < 2; s++) begin
            if (st_d[s] == OWNED)
                gnt_d[own_d[s]] = 1'b1;
        end
    end

    // At most two bits set, so a 2-bit sum cannot wrap
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++)
            cnt = cnt + 2'(gnt_q[i]);
    end

    assign bus.gnt        = gnt_q;
    assign bus.gnt_new    = new_q;
    assign bus.revoked    = rev_q;
    assign bus.active_cnt = cnt;
    assign bus.one_or_two = (cnt == 2'd1) || (cnt == 2'd2);
endmodule

// File: tb/tb_dual_slot_rr_arbiter_10.sv
// Directed plus random checks of the dual-slot arbiter
// against a slot/owner list reference model.
module tb_dual_slot_rr_arbiter_10;
    localparam int MAXH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dual_slot_rr_arbiter_10_if bus ();

    dual_slot_rr_arbiter_10 #(
        .MAX_HOLD(MAXH),
        .HOLD_W  (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int m_own [2];
    int m_age [2];
    int m_ptr;
    logic [9:0] e_gnt, e_new, e_rev;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    function automatic int popc(input logic [9:0] v);
        int n = 0;
        for (int i = 0; i < 10; i++)
            n += int'(v[i]);
        return n;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < 2; s++) begin
            m_own[s] = -1;
            m_age[s] = 0;
        end
        m_ptr = 0;
        e_gnt = '0;
        e_new = '0;
        e_rev = '0;
    endtask

    // One clock edge of the reference: leave, pick, seat
    task automatic m_step(input logic [9:0] r,
                          input logic [9:0] l);
        bit leave [2];
        logic [9:0] held;
        int win;
        int slot;
        int i;
        e_new = '0;
        e_rev = '0;
        held  = '0;
        for (int s = 0; s < 2; s++) begin
            leave[s] = 1'b0;
            if (m_own[s] >= 0) begin
                held[m_own[s]] = 1'b1;
                if (l[m_own[s]])
                    leave[s] = 1'b1;
                else if (MAXH != 0 && m_age[s] == MAXH - 1) begin
                    leave[s] = 1'b1;
                    e_rev[m_own[s]] = 1'b1;
                end
            end
        end
        win = -1;
        for (int k = 0; k < 10; k++) begin
            i = (m_ptr + k) % 10;
            if (win < 0 && r[i] && !held[i])
                win = i;
        end
        for (int s = 0; s < 2; s++) begin
            if (leave[s]) begin
                m_own[s] = -1;
                m_age[s] = 0;
            end else if (m_own[s] >= 0) begin
                m_age[s]++;
            end
        end
        slot = (m_own[0] < 0) ? 0 : ((m_own[1] < 0) ? 1 : -1);
        if (win >= 0 && slot >= 0) begin
            m_own[slot] = win;
            m_age[slot] = 0;
            m_ptr = (win + 1) % 10;
            e_new[win] = 1'b1;
        end
        e_gnt = '0;
        for (int s = 0; s < 2; s++)
            if (m_own[s] >= 0)
                e_gnt[m_own[s]] = 1'b1;
    endtask

    task automatic check_all(input string tag);
        int pc;
        pc = popc(e_gnt);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(e_gnt));
        chk({tag, ".new"}, 32'(bus.gnt_new), 32'(e_new));
        chk({tag, ".rev"}, 32'(bus.revoked), 32'(e_rev));
        chk({tag, ".cnt"}, 32'(bus.active_cnt), 32'(pc));
        chk({tag, ".o12"}, 32'(bus.one_or_two),
            32'(pc == 1 || pc == 2));
    endtask

    task automatic cycle(input string tag,
                         input logic [9:0] r,
                         input logic [9:0] l);
        bus.req = r;
        bus.rel = l;
        m_step(r, l);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [9:0] pend;
        logic [9:0] rr;
        logic [9:0] rl;

        bus.req = '0;
        bus.rel = '0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // single requester
        cycle("t1", 10'h001, 10'h000);
        chk("t1_gnt", 32'(bus.gnt), 32'h001);
        chk("t1_new", 32'(bus.gnt_new), 32'h001);
        cycle("t1r", 10'h000, 10'h001);

        // both slots busy, third waits, then takes freed slot
        cycle("t3a", 10'h008, 10'h000);
        cycle("t3b", 10'h088, 10'h000);
        cycle("t3c", 10'h0A8, 10'h000);
        chk("t3_wait", 32'(bus.gnt), 32'h088);
        cycle("t3d", 10'h0A8, 10'h008);
        chk("t3_gnt", 32'(bus.gnt), 32'h0A0);
        chk("t3_new", 32'(bus.gnt_new), 32'h020);
        cycle("t3r", 10'h000, 10'h0A0);

        // release coincides with timeout
        cycle("t5a", 10'h004, 10'h000);
        for (int k = 0; k < MAXH - 1; k++)
            cycle("t5b", 10'h004, 10'h000);
        cycle("t5c", 10'h004, 10'h004);
        chk("t5_rev", 32'(bus.revoked), 32'h000);

        // timeout revoke and re-grant
        for (int k = 0; k < MAXH; k++) begin
            cycle("t4a", 10'h004, 10'h000);
            chk("t4_hold", 32'(bus.gnt), 32'h004);
        end
        cycle("t4b", 10'h004, 10'h000);
        chk("t4_rev", 32'(bus.revoked), 32'h004);
        chk("t4_gone", 32'(bus.gnt), 32'h000);
        cycle("t4c", 10'h004, 10'h000);
        chk("t4_regnt", 32'(bus.gnt_new), 32'h004);
        cycle("t5d", 10'h004, 10'h3FB);
        chk("t5_nonown", 32'(bus.gnt), 32'h004);
        cycle("t5r", 10'h000, 10'h004);

        // all requesting, release right after each grant
        pend = '0;
        for (int k = 0; k < 24; k++) begin
            cycle("t2", 10'h3FF, pend);
            pend = e_new;
        end
        cycle("t2r", 10'h000, e_gnt);

        // async reset while two slots are owned
        cycle("t6a", 10'h300, 10'h000);
        cycle("t6b", 10'h300, 10'h000);
        chk("t6_pre", 32'(bus.active_cnt), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("t6_gnt", 32'(bus.gnt), 32'h000);
        chk("t6_cnt", 32'(bus.active_cnt), 32'd0);
        chk("t6_o12", 32'(bus.one_or_two), 32'd0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle("t6c", 10'h3FF, 10'h000);
        chk("t6_ptr0", 32'(bus.gnt), 32'h001);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            rr = 10'($urandom);
            rl = 10'($urandom) & 10'($urandom);
            cycle("rnd", rr, rl);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
